// File: rtl/hms_time_counter_if.sv
// Control and display bundle of the time-of-day counter.
// master: the side that drives the mode/set/increment controls.
// slave: the counter, which drives the display values and the pulses.
interface hms_time_counter_if;
    logic       mode_24h;
    logic       set_en;
    logic       inc_hour;
    logic       inc_min;
    logic       clr_sec;
    logic [4:0] hour_disp;
    logic [5:0] min;
    logic [5:0] sec;
    logic       pm;
    logic       tick_1hz;
    logic       day_wrap;

    modport master (
        output mode_24h, set_en, inc_hour, inc_min, clr_sec,
        input  hour_disp, min, sec, pm, tick_1hz, day_wrap
    );

    modport slave (
        input  mode_24h, set_en, inc_hour, inc_min, clr_sec,
        output hour_disp, min, sec, pm, tick_1hz, day_wrap
    );
endinterface

// File: rtl/hms_time_counter.sv
// Time-of-day counter: prescales clk to a 1 Hz tick, counts hh:mm:ss on a
// 24 h base, and offers a set mode in which time is frozen and the hour and
// minute can be stepped and the seconds cleared.
module hms_time_counter #(
    parameter int TICK_DIV = 50_000_000,
    parameter int DIV_W    = 26
) (
    input  logic               clk,
    input  logic               rst,
    hms_time_counter_if.slave  bus
);

    logic [DIV_W-1:0] presc;
    logic [5:0]       sec_q;
    logic [5:0]       min_q;
    logic [4:0]       hour24;
    logic             tick_q;
    logic             wrap_q;
    logic [4:0]       disp;

    logic presc_last;
    logic run_tick;
    logic at_day_end;

    assign presc_last = (presc == DIV_W'(TICK_DIV - 1));
    // Set mode wins over a tick falling on the same edge.
    assign run_tick   = !bus.set_en && presc_last;
    assign at_day_end = (sec_q == 6'd59) && (min_q == 6'd59) && (hour24 == 5'd23);

    // Prescaler plus registered tick and day-wrap pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc  <= '0;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
        end else begin
            tick_q <= run_tick;
            wrap_q <= run_tick && at_day_end;
            if (bus.set_en || presc_last) begin
                presc <= '0;
            end else begin
                presc <= presc + 1'b1;
            end
        end
    end

    // Time registers: manual adjustment in set mode, full carry chain on a tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            sec_q  <= '0;
            min_q  <= '0;
            hour24 <= '0;
        end else if (bus.set_en) begin
            if (bus.inc_hour) begin
                hour24 <= (hour24 == 5'd23) ? 5'd0 : hour24 + 5'd1;
            end
            if (bus.inc_min) begin
                min_q <= (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end
            if (bus.clr_sec) begin
                sec_q <= '0;
            end
        end else if (run_tick) begin
            if (sec_q == 6'd59) begin
                sec_q <= '0;
                if (min_q == 6'd59) begin
                    min_q  <= '0;
                    hour24 <= (hour24 == 5'd23) ? 5'd0 : hour24 + 5'd1;
                end else begin
                    min_q <= min_q + 6'd1;
                end
            end else begin
                sec_q <= sec_q + 6'd1;
            end
        end
    end

    // Display hour decode: 24 h passes through, 12 h maps 0 -> 12 and 13..23 -> 1..11.
    always_comb begin
        disp = hour24;
        if (!bus.mode_24h) begin
            if (hour24 == 5'd0) begin
                disp = 5'd12;
            end else if (hour24 > 5'd12) begin
                disp = hour24 - 5'd12;
            end
        end
    end

    assign bus.hour_disp = disp;
    assign bus.min       = min_q;
    assign bus.sec       = sec_q;
    assign bus.pm        = (hour24 >= 5'd12);
    assign bus.tick_1hz  = tick_q;
    assign bus.day_wrap  = wrap_q;

    hour_range_a:  assert property (@(posedge clk) hour24 <= 5'd23);
    min_range_a:   assert property (@(posedge clk) min_q <= 6'd59);
    sec_range_a:   assert property (@(posedge clk) sec_q <= 6'd59);
    presc_range_a: assert property (@(posedge clk) presc <= DIV_W'(TICK_DIV - 1));

endmodule

// File: tb/tb_hms_time_counter.sv
// Directed bench for hms_time_counter with TICK_DIV=4.
module tb_hms_time_counter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   set_ticks;
    int   c;

    hms_time_counter_if bus ();

    hms_time_counter #(
        .TICK_DIV (4),
        .DIV_W    (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One-cycle control pulse; also records any tick seen while it is applied.
    task automatic pulse(input logic h, input logic m, input logic s);
        bus.inc_hour = h;
        bus.inc_min  = m;
        bus.clr_sec  = s;
        step();
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        bus.clr_sec  = 1'b0;
        if (bus.tick_1hz || bus.day_wrap) set_ticks++;
    endtask

    // Steps until tick_1hz is seen; returns the number of cycles, capped at 20.
    task automatic wait_tick(output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while (!bus.tick_1hz && cnt < 20);
    endtask

    task automatic check_time(input string tag, input int h, input int m, input int s);
        check({tag, "_hour"}, 32'(bus.hour_disp), 32'(h));
        check({tag, "_min"},  32'(bus.min),       32'(m));
        check({tag, "_sec"},  32'(bus.sec),       32'(s));
    endtask

    initial begin
        n_checks     = 0;
        n_fail       = 0;
        set_ticks    = 0;
        rst          = 1'b1;
        bus.mode_24h = 1'b1;
        bus.set_en   = 1'b0;
        bus.inc_hour = 1'b0;
        bus.inc_min  = 1'b0;
        bus.clr_sec  = 1'b0;

        // Reset state
        step();
        step();
        rst = 1'b0;
        check_time("reset", 0, 0, 0);
        check("reset_pm",   32'(bus.pm),       0);
        check("reset_tick", 32'(bus.tick_1hz), 0);
        check("reset_wrap", 32'(bus.day_wrap), 0);
        bus.mode_24h = 1'b0;
        #1;
        check("reset_disp12", 32'(bus.hour_disp), 12);
        bus.mode_24h = 1'b1;
        #1;

        // Free run: tick every 4 cycles, three ticks give sec=3
        wait_tick(c);
        check("first_tick_lat", 32'(c), 4);
        check("sec_after_1", 32'(bus.sec), 1);
        wait_tick(c);
        check("tick_period_2", 32'(c), 4);
        wait_tick(c);
        check("tick_period_3", 32'(c), 4);
        check("sec_after_3", 32'(bus.sec), 3);
        step();
        check("tick_one_cycle", 32'(bus.tick_1hz), 0);

        // Set mode: clear seconds, 23 hour and 59 minute pulses
        bus.set_en = 1'b1;
        step();
        set_ticks = 0;
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 59; i++) pulse(i < 23, 1'b1, 1'b0);
        check_time("set_2359", 23, 59, 0);
        check("set_2359_pm", 32'(bus.pm), 1);
        bus.mode_24h = 1'b0;
        #1;
        check("set_23_disp12", 32'(bus.hour_disp), 11);
        bus.mode_24h = 1'b1;
        #1;
        check("set_no_tick_a", 32'(set_ticks), 0);

        // Release: first tick 4 cycles later, 59 ticks reach 23:59:59
        bus.set_en = 1'b0;
        wait_tick(c);
        check("release_lat", 32'(c), 4);
        for (int i = 0; i < 58; i++) wait_tick(c);
        check_time("pre_wrap", 23, 59, 59);
        check("pre_wrap_dw", 32'(bus.day_wrap), 0);
        wait_tick(c);
        check("wrap_period", 32'(c), 4);
        check_time("wrap", 0, 0, 0);
        check("wrap_dw",   32'(bus.day_wrap), 1);
        check("wrap_pm",   32'(bus.pm),       0);
        step();
        check("wrap_dw_one_cycle", 32'(bus.day_wrap), 0);
        check("wrap_tick_one_cycle", 32'(bus.tick_1hz), 0);

        // Display decode at hour24 = 12 and 13
        bus.set_en = 1'b1;
        step();
        set_ticks = 0;
        for (int i = 0; i < 12; i++) pulse(1'b1, 1'b0, 1'b0);
        check("h12_disp24", 32'(bus.hour_disp), 12);
        check("h12_pm",     32'(bus.pm),        1);
        bus.mode_24h = 1'b0;
        #1;
        check("h12_disp12", 32'(bus.hour_disp), 12);
        pulse(1'b1, 1'b0, 1'b0);
        check("h13_disp12", 32'(bus.hour_disp), 1);
        check("h13_pm",     32'(bus.pm),        1);
        bus.mode_24h = 1'b1;
        #1;
        check("h13_disp24", 32'(bus.hour_disp), 13);

        // Simultaneous hour and minute pulses wrapping at 23 h / 59 min
        for (int i = 0; i < 58; i++) pulse(i < 10, 1'b1, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
        check_time("set_wrap_pre", 23, 59, 0);
        pulse(1'b1, 1'b1, 1'b0);
        check_time("set_wrap", 0, 0, 0);
        check("set_no_tick_b", 32'(set_ticks), 0);

        // Run to sec=37, then enter set mode on the edge a tick would fire
        bus.set_en = 1'b0;
        for (int i = 0; i < 37; i++) wait_tick(c);
        check_time("run_37", 0, 0, 37);
        step();
        step();
        step();
        bus.set_en = 1'b1;
        step();
        check("set_drops_tick", 32'(bus.tick_1hz), 0);
        check("set_frozen_sec", 32'(bus.sec), 37);
        pulse(1'b0, 1'b0, 1'b1);
        check_time("clr_sec", 0, 0, 0);

        // Run mode ignores inc_hour, inc_min and clr_sec
        bus.set_en = 1'b0;
        wait_tick(c);
        pulse(1'b1, 1'b1, 1'b1);
        check_time("run_ignore", 0, 0, 1);

        // Reset during the carry out of 00:59:59
        bus.set_en = 1'b1;
        step();
        pulse(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 59; i++) pulse(1'b0, 1'b1, 1'b0);
        bus.set_en = 1'b0;
        for (int i = 0; i < 59; i++) wait_tick(c);
        check_time("pre_rst", 0, 59, 59);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_time("rst_carry", 0, 0, 0);
        check("rst_carry_tick", 32'(bus.tick_1hz), 0);
        check("rst_carry_dw",   32'(bus.day_wrap), 0);
        check("rst_carry_pm",   32'(bus.pm),       0);
        step();
        check("rst_after_tick", 32'(bus.tick_1hz), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
